rs_drive_ctrl: RTL and testbench

RS_DRIVE_CTRL -- requirements
Module: rs_drive_ctrl

---
 rtl/rs_pkg.sv | 15 +
 rtl/rs_sync2.sv | 25 ++
 rtl/rs_drive_ctrl.sv | 151 +++++++++++++++
 tb/tb_rs_drive_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared state encoding and counter widths for the RS drive controller.
// Imported by rs_drive_ctrl; no logic of its own.
package rs_pkg;

  localparam int DBNC_W  = 8;
  localparam int PULSE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    PULSE    = 2'd2,
    WAIT_REL = 2'd3
  } rs_state_e;

endpackage

// File: rtl/rs_sync2.sv
// Two-flop synchronizer bringing one asynchronous level into the clk domain.
// Latency 2 cycles; no backpressure.
module rs_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rs_drive_ctrl.sv
// Debounces async set/clear requests and drives one PULSE_LEN-cycle s or r pulse per press.
// s/r first high DEBOUNCE+3 edges after the request is sampled; RS_DRV_CONFLICT_CNT_EN adds conflict_cnt.
module rs_drive_ctrl
  import rs_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
`ifdef RS_DRV_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam logic [DBNC_W-1:0]  DBNC_MAX  = DBNC_W'(DEBOUNCE);
  localparam logic [DBNC_W-1:0]  DBNC_ONE  = DBNC_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(PULSE_LEN);
  localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1);

  logic       set_s;
  logic       clr_s;
  logic [1:0] req_pat;

  rs_sync2 u_sync_set (.clk(clk), .rst_n(rst_n), .d(set_req), .q(set_s));
  rs_sync2 u_sync_clr (.clk(clk), .rst_n(rst_n), .d(clr_req), .q(clr_s));

  // bit 1 = set, bit 0 = clear
  assign req_pat = {set_s, clr_s};

  rs_state_e          state_q, state_d;
  logic [DBNC_W-1:0]  dcnt_q, dcnt_d;
  logic [PULSE_W-1:0] pcnt_q, pcnt_d;
  logic [1:0]         pat_q, pat_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               conflict_q, conflict_d;

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    pcnt_d     = pcnt_q;
    pat_d      = pat_q;
    s_d        = s_q;
    r_d        = r_q;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_pat != 2'b00) begin
          state_d = QUAL;
          dcnt_d  = DBNC_ONE;
          pat_d   = req_pat;
        end
      end
      QUAL: begin
        if ((pat_q & ~req_pat) != 2'b00) begin
          state_d = IDLE;
          dcnt_d  = '0;
          pat_d   = 2'b00;
        end else if (req_pat != pat_q) begin
          // second request joined: qualify the combined pattern from scratch
          dcnt_d = DBNC_ONE;
          pat_d  = req_pat;
        end else if (dcnt_q == DBNC_MAX) begin
          dcnt_d = '0;
          if (pat_q == 2'b11) begin
            conflict_d = 1'b1;
            state_d    = WAIT_REL;
          end else begin
            state_d = PULSE;
            s_d     = pat_q[1];
            r_d     = pat_q[0];
            pcnt_d  = PULSE_ONE;
          end
        end else begin
          dcnt_d = dcnt_q + DBNC_ONE;
        end
      end
      PULSE: begin
        if (pcnt_q == PULSE_MAX) begin
          state_d = WAIT_REL;
          s_d     = 1'b0;
          r_d     = 1'b0;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PULSE_ONE;
        end
      end
      WAIT_REL: begin
        if (req_pat == 2'b00) begin
          state_d = IDLE;
          pat_d   = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      pcnt_q     <= '0;
      pat_q      <= 2'b00;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      pcnt_q     <= pcnt_d;
      pat_q      <= pat_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = (state_q != IDLE);
  assign conflict = conflict_q;

`ifdef RS_DRV_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_q && (conflict_cnt_q != 8'hFF)) begin
      conflict_cnt_d = conflict_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= 8'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rs_drive_ctrl.sv
// Bench for rs_drive_ctrl: timestamp-based reference model checked every cycle plus directed literals.
// Define RS_DRV_CONFLICT_CNT_EN to also exercise the saturating conflict counter.
module tb_rs_drive_ctrl;

  localparam int DEBOUNCE  = 4;
  localparam int PULSE_LEN = 2;

  logic clk;
  logic rst_n;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;
`ifdef RS_DRV_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int total;
  int bad;

  rs_drive_ctrl #(.DEBOUNCE(DEBOUNCE), .PULSE_LEN(PULSE_LEN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_req(set_req),
    .clr_req(clr_req),
    .s(s),
    .r(r),
    .busy(busy),
    .conflict(conflict)
`ifdef RS_DRV_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request pattern seen by the controller lags the pins by two edges;
  // qualification and pulse length are measured as edge-count differences from timestamps.
  int         m_mode;   // 0 idle, 1 qualifying, 2 pulsing, 3 waiting for release
  int         n_edge;
  int         q_t0;
  int         p_t0;
  int         m_ccnt;
  int         s_run;
  int         r_run;
  logic [1:0] m_pat;
  logic [1:0] d1;
  logic [1:0] d2;
  logic [1:0] seen;
  logic [1:0] cur;
  logic       m_conf;

  always @(posedge clk) begin
    cur = {set_req, clr_req};
    if (!rst_n) begin
      m_mode = 0;
      n_edge = 0;
      m_pat  = 2'b00;
      d1     = 2'b00;
      d2     = 2'b00;
      m_conf = 1'b0;
      m_ccnt = 0;
      s_run  = 0;
      r_run  = 0;
    end else begin
      n_edge++;
      seen = d2;
      d2   = d1;
      d1   = cur;
      if (m_conf && m_ccnt < 255) m_ccnt++;
      m_conf = 1'b0;
      case (m_mode)
        0: if (seen != 2'b00) begin
             m_mode = 1;
             q_t0   = n_edge;
             m_pat  = seen;
           end
        1: if ((m_pat & ~seen) != 2'b00) begin
             m_mode = 0;
           end else if (seen != m_pat) begin
             q_t0  = n_edge;
             m_pat = seen;
           end else if (n_edge - q_t0 == DEBOUNCE) begin
             if (m_pat == 2'b11) begin
               m_conf = 1'b1;
               m_mode = 3;
             end else begin
               m_mode = 2;
               p_t0   = n_edge;
             end
           end
        2: if (n_edge - p_t0 == PULSE_LEN) m_mode = 3;
        3: if (seen == 2'b00) m_mode = 0;
        default: m_mode = 0;
      endcase
      #1;
      chk("model_s", {31'd0, s}, {31'd0, (m_mode == 2 && m_pat == 2'b10)});
      chk("model_r", {31'd0, r}, {31'd0, (m_mode == 2 && m_pat == 2'b01)});
      chk("model_busy", {31'd0, busy}, {31'd0, (m_mode != 0)});
      chk("model_conflict", {31'd0, conflict}, {31'd0, m_conf});
      chk("s_and_r", {31'd0, (s && r)}, 32'd0);
`ifdef RS_DRV_CONFLICT_CNT_EN
      chk("model_conflict_cnt", {24'd0, conflict_cnt}, m_ccnt);
`endif
      if (s) s_run++;
      else if (s_run != 0) begin
        chk("pulse_len_s", s_run, PULSE_LEN);
        s_run = 0;
      end
      if (r) r_run++;
      else if (r_run != 0) begin
        chk("pulse_len_r", r_run, PULSE_LEN);
        r_run = 0;
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", {31'd0, s}, 32'd0);
    chk("rst_r", {31'd0, r}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_conflict", {31'd0, conflict}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);

    // Set held 20 edges: s high after edges 7 and 8 only.
    set_req = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #2;
      chk("s1_s", {31'd0, s}, {31'd0, (e == 7 || e == 8)});
      chk("s1_r", {31'd0, r}, 32'd0);
      chk("s1_busy", {31'd0, busy}, {31'd0, (e >= 3)});
    end
    @(negedge clk);
    set_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #2;
      chk("s1_busy_release", {31'd0, busy}, {31'd0, (k <= 2)});
    end
    gap(2);

    // Clear bounce of three edges: never qualifies.
    clr_req = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #2;
      chk("s2_r", {31'd0, r}, 32'd0);
      chk("s2_busy", {31'd0, busy}, {31'd0, (e >= 3 && e <= 5)});
      if (e == 3) begin
        @(negedge clk);
        clr_req = 1'b0;
      end
    end
    gap(2);

    // Both rise together: one conflict pulse at edge 7, no drive.
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #2;
      chk("s3_conflict", {31'd0, conflict}, {31'd0, (e == 7)});
      chk("s3_s", {31'd0, s}, 32'd0);
      chk("s3_r", {31'd0, r}, 32'd0);
    end
    @(negedge clk);
    set_req = 1'b0;
    clr_req = 1'b0;
    gap(4);

    // Reset in the second pulse cycle kills s at once and nothing resumes.
    set_req = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("s4_s_before_rst", {31'd0, s}, 32'd1);
    set_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("s4_s_async", {31'd0, s}, 32'd0);
    chk("s4_busy_async", {31'd0, busy}, 32'd0);
    gap(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #2;
      chk("s4_no_pulse", {31'd0, s}, 32'd0);
    end
    gap(1);

    // Request held across a reset is debounced from scratch after release.
    set_req = 1'b1;
    gap(3);
    rst_n = 1'b0;
    gap(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #2;
      chk("s4b_s", {31'd0, s}, {31'd0, (e == 7 || e == 8)});
    end
    @(negedge clk);
    set_req = 1'b0;
    gap(4);

`ifdef RS_DRV_CONFLICT_CNT_EN
    // Scenario-5 counter saturation; the counter was cleared by the resets above.
    for (int i = 0; i < 300; i++) begin
      set_req = 1'b1;
      clr_req = 1'b1;
      gap(8);
      set_req = 1'b0;
      clr_req = 1'b0;
      gap(4);
      if (i == 0) chk("s5_cnt_first", {24'd0, conflict_cnt}, 32'd1);
    end
    chk("s5_cnt_sat", {24'd0, conflict_cnt}, 32'd255);
`endif

    // Random traffic: model and pulse-length checks run every cycle.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(9) == 0) set_req = ~set_req;
      if ($urandom_range(9) == 0) clr_req = ~clr_req;
    end
    @(negedge clk);
    set_req = 1'b0;
    clr_req = 1'b0;
    gap(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
